int_bus_aggregator: RTL and testbench
=====================================

// Module: int_bus_aggregator
// PURPOSE
//  Parametrised interrupt bus stage: synchronises NUM_IN async interrupt sources into
//  the bus clock domain, latches per-source pending state (level or edge mode), applies
//  an enable mask and ORs sources onto NUM_OUT bus lines. Also reports the lowest
//  pending+enabled source for claim/clear by the consuming interrupt controller (PLIC/CLINT side).
// PARAMETERS
//  NUM_IN       8   number of interrupt sources (>=1)
//  NUM_OUT      2   number of output bus lines (1..NUM_IN)
//  SYNC_STAGES  2   synchroniser flops per source; 0 = inputs already synchronous (bypass)
//  EDGE_MASK    0   NUM_IN-bit; bit i=1 -> source i edge-triggered, 0 -> level
//  IDXW         $clog2(NUM_IN), min 1 (localparam)
// PORTS
//  clock        in   1        bus clock
//  reset        in   1        asynchronous, active-high reset
//  int_in       in   NUM_IN   raw interrupt sources, active-high
//  int_en       in   NUM_IN   per-source enable mask (synchronous to clock)
//  clr_valid    in   1        one-cycle clear request
//  clr_idx      in   IDXW     source index to clear
//  int_out      out  NUM_OUT  aggregated bus interrupt lines (registered)
//  pending      out  NUM_IN   raw pending vector (registered, ignores int_en)
//  claim_valid  out  1        |(pending & int_en)
//  claim_idx    out  IDXW     lowest index i with pending[i] & int_en[i]; 0 when none
// BEHAVIOUR
//  - Reset (async assert, sync deassert by environment): sync chains, edge history
//    prev, pending, int_out all clear to 0. claim_valid=0, claim_idx=0.
//  - sync[i] = last synchroniser stage (int_in[i] directly if SYNC_STAGES==0).
//  - prev[i] <= sync[i] every cycle.
//  - Level source: pending[i] <= sync[i] each cycle; clr_valid for it is ignored.
//  - Edge source: set = sync[i] & ~prev[i]; clr = clr_valid & (clr_idx==i).
//    pending[i] <= set ? 1 : clr ? 0 : pending[i]. Set and clear same cycle -> set wins.
//  - Source held high through reset on an edge channel: prev=0 after reset, so exactly
//    one pending set occurs once the high level reaches sync.
//  - clr_idx >= NUM_IN: ignored, no state change.
//  - Routing: source i drives line j = i % NUM_OUT.
//    int_out[j] <= OR over i (i%NUM_OUT==j) of pending[i] & int_en[i].
//  - Latency int_in rise -> int_out rise: SYNC_STAGES+2 clock edges (both modes);
//    int_en change -> int_out: 1 edge; clear -> int_out fall: 2 edges (pending, then int_out).
//  - claim_valid/claim_idx: combinational from registered pending and int_en; fixed
//    priority, lowest index wins; no state of their own.
//  - Edge pulses narrower than one clock period may be missed; not required to capture.
//  - Reset mid-operation: all pending edges discarded; no output glitch beyond async clear.
// TESTING
//  1. NUM_IN=8,NUM_OUT=2,SYNC=2, level src 3, en=0xFF: int_in[3] 0->1 at cycle 0 ->
//     pending[3]=1 after edge 3, int_out=2'b10 after edge 4; drop input -> clears same latency.
//  2. EDGE_MASK=0x01, pulse int_in[0] high 3 cycles -> pending[0] stays 1 after input
//     falls; claim_valid=1, claim_idx=0; clr_valid,clr_idx=0 -> pending[0]=0 next edge,
//     int_out[0]=0 one edge later.
//  3. Edge src 0 set edge and clr_valid/clr_idx=0 same cycle -> pending[0]=1 (set wins).
//  4. Level srcs 2 and 5 high, en=0xFF -> claim_idx=2; en[2]=0 -> claim_idx=5,
//     int_out[0]=0 next edge, int_out[1]=1.
//  5. clr_valid with clr_idx=7 on NUM_IN=6 -> no pending change; clr on level src -> ignored.
//  6. Edge src held high, assert reset mid-run, release -> pending cleared during reset,
//     single re-set SYNC+1 edges after release, no second set while input stays high.

Source files
------------

// File: rtl/int_bus_aggregator.sv
// int_bus_aggregator
// Interrupt bus stage. It synchronises NUM_IN asynchronous sources into the bus clock
// domain and keeps a pending bit for each source. A source can be level or edge
// triggered. The pending bits are masked by int_en and ORed onto NUM_OUT bus lines.
// The block also reports the lowest pending and enabled source so the downstream
// controller can claim and clear it.
module int_bus_aggregator #(
    parameter int                NUM_IN      = 8,
    parameter int                NUM_OUT     = 2,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_IN-1:0] EDGE_MASK   = '0,
    localparam int               IDXW        = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_IN-1:0]   int_in,
    input  logic [NUM_IN-1:0]   int_en,
    input  logic                clr_valid,
    input  logic [IDXW-1:0]     clr_idx,
    output logic [NUM_OUT-1:0]  int_out,
    output logic [NUM_IN-1:0]   pending,
    output logic                claim_valid,
    output logic [IDXW-1:0]     claim_idx
);

    // sync is the last synchroniser stage. It is int_in itself when the sources
    // are already synchronous to the bus clock.
    logic [NUM_IN-1:0] sync;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sync = int_in;
        end else begin : g_sync
            logic [NUM_IN-1:0] sync_d [SYNC_STAGES];
            logic [NUM_IN-1:0] sync_q [SYNC_STAGES];

            // Shift each source one stage along its synchroniser chain.
            always_comb begin
                sync_d[0] = int_in;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            // Synchroniser flops. Reset clears the whole chain.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_d[s];
                    end
                end
            end

            assign sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [NUM_IN-1:0]  prev_d,    prev_q;
    logic [NUM_IN-1:0]  pending_d, pending_q;
    logic [NUM_OUT-1:0] int_out_d, int_out_q;
    logic [IDXW-1:0]    claim_idx_c;
    logic               claim_valid_c;

    // Update edge history and pending bits.
    // On an edge source, a set and a clear in the same cycle resolve to set, so no
    // edge is lost. A clear that names an index outside the source range never
    // matches any source and is therefore ignored.
    always_comb begin
        prev_d    = sync;
        pending_d = pending_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (EDGE_MASK[i]) begin
                if (sync[i] && !prev_q[i]) begin
                    pending_d[i] = 1'b1;
                end else if (clr_valid && (clr_idx == IDXW'(i))) begin
                    pending_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = sync[i];
            end
        end
    end

    // OR the masked pending bits onto the bus lines. Source i drives line i % NUM_OUT.
    always_comb begin
        int_out_d = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if ((i % NUM_OUT) == j) begin
                    int_out_d[j] = int_out_d[j] | (pending_q[i] & int_en[i]);
                end
            end
        end
    end

    // Registers for edge history, pending state and the bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
            int_out_q <= '0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            int_out_q <= int_out_d;
        end
    end

    // Fixed-priority claim: the lowest pending and enabled index wins. The loop scans
    // from the top down so the lowest match is written last.
    always_comb begin
        claim_valid_c = 1'b0;
        claim_idx_c   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (pending_q[i] && int_en[i]) begin
                claim_valid_c = 1'b1;
                claim_idx_c   = IDXW'(i);
            end
        end
    end

    assign int_out     = int_out_q;
    assign pending     = pending_q;
    assign claim_valid = claim_valid_c;
    assign claim_idx   = claim_idx_c;

endmodule

// File: tb/tb_int_bus_aggregator.sv
// Directed bench for int_bus_aggregator.
// Instance a: 8 sources, 2 lines, 2 synchroniser stages, source 0 edge-triggered.
// Instance b: 6 sources, 3 lines, no synchroniser, all sources edge-triggered.
module tb_int_bus_aggregator;

    logic       clock;
    logic       reset;

    logic [7:0] a_int_in, a_int_en;
    logic       a_clr_valid;
    logic [2:0] a_clr_idx;
    logic [1:0] a_int_out;
    logic [7:0] a_pending;
    logic       a_claim_valid;
    logic [2:0] a_claim_idx;

    logic [5:0] b_int_in, b_int_en;
    logic       b_clr_valid;
    logic [2:0] b_clr_idx;
    logic [2:0] b_int_out;
    logic [5:0] b_pending;
    logic       b_claim_valid;
    logic [2:0] b_claim_idx;

    int passed = 0;
    int total  = 0;

    int_bus_aggregator #(
        .NUM_IN(8), .NUM_OUT(2), .SYNC_STAGES(2), .EDGE_MASK(8'h01)
    ) u_a (
        .clock(clock), .reset(reset),
        .int_in(a_int_in), .int_en(a_int_en),
        .clr_valid(a_clr_valid), .clr_idx(a_clr_idx),
        .int_out(a_int_out), .pending(a_pending),
        .claim_valid(a_claim_valid), .claim_idx(a_claim_idx)
    );

    int_bus_aggregator #(
        .NUM_IN(6), .NUM_OUT(3), .SYNC_STAGES(0), .EDGE_MASK(6'h3F)
    ) u_b (
        .clock(clock), .reset(reset),
        .int_in(b_int_in), .int_en(b_int_en),
        .clr_valid(b_clr_valid), .clr_idx(b_clr_idx),
        .int_out(b_int_out), .pending(b_pending),
        .claim_valid(b_claim_valid), .claim_idx(b_claim_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Step to just after the next rising edge, so inputs are driven and outputs
    // are sampled away from the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        a_int_in = '0; a_int_en = 8'hFF; a_clr_valid = 1'b0; a_clr_idx = '0;
        b_int_in = '0; b_int_en = 6'h3F; b_clr_valid = 1'b0; b_clr_idx = '0;
        tick(2);
        check("rst_a_pending", 32'(a_pending), 32'h00);
        check("rst_a_int_out", 32'(a_int_out), 32'h0);
        check("rst_a_claim_valid", 32'(a_claim_valid), 32'h0);
        check("rst_a_claim_idx", 32'(a_claim_idx), 32'h0);
        check("rst_b_pending", 32'(b_pending), 32'h00);
        reset = 1'b0;
        tick(2);

        // Level source 3: pending rises after edge 3 and int_out after edge 4.
        a_int_in[3] = 1'b1;
        tick(2);
        check("t1_pending_e2", 32'(a_pending), 32'h00);
        tick(1);
        check("t1_pending_e3", 32'(a_pending), 32'h08);
        check("t1_int_out_e3", 32'(a_int_out), 32'h0);
        tick(1);
        check("t1_int_out_e4", 32'(a_int_out), 32'h2);
        check("t1_claim_valid", 32'(a_claim_valid), 32'h1);
        check("t1_claim_idx", 32'(a_claim_idx), 32'h3);
        a_int_in[3] = 1'b0;
        tick(3);
        check("t1_fall_pending_e3", 32'(a_pending), 32'h00);
        check("t1_fall_int_out_e3", 32'(a_int_out), 32'h2);
        tick(1);
        check("t1_fall_int_out_e4", 32'(a_int_out), 32'h0);

        // Edge source 0: pending stays set after the input falls, then is cleared.
        a_int_in[0] = 1'b1;
        tick(3);
        check("t2_pending_set", 32'(a_pending), 32'h01);
        a_int_in[0] = 1'b0;
        tick(3);
        check("t2_pending_held", 32'(a_pending), 32'h01);
        check("t2_int_out", 32'(a_int_out), 32'h1);
        check("t2_claim_valid", 32'(a_claim_valid), 32'h1);
        check("t2_claim_idx", 32'(a_claim_idx), 32'h0);
        a_clr_valid = 1'b1; a_clr_idx = 3'd0;
        tick(1);
        a_clr_valid = 1'b0;
        check("t2_clr_pending", 32'(a_pending), 32'h00);
        check("t2_clr_int_out_e1", 32'(a_int_out), 32'h1);
        tick(1);
        check("t2_clr_int_out_e2", 32'(a_int_out), 32'h0);
        check("t2_clr_claim_valid", 32'(a_claim_valid), 32'h0);

        // A set and a clear in the same cycle: set wins.
        a_int_in[0] = 1'b1;
        tick(2);
        a_clr_valid = 1'b1; a_clr_idx = 3'd0;
        tick(1);
        a_clr_valid = 1'b0;
        check("t3_set_wins", 32'(a_pending), 32'h01);
        a_clr_valid = 1'b1;
        tick(1);
        a_clr_valid = 1'b0;
        check("t3_clear_after", 32'(a_pending), 32'h00);
        tick(2);
        check("t3_no_reset_while_high", 32'(a_pending), 32'h00);
        a_int_in[0] = 1'b0;
        tick(4);

        // Priority and enable mask with level sources 2 and 5.
        a_int_in[2] = 1'b1; a_int_in[5] = 1'b1;
        tick(4);
        check("t4_pending", 32'(a_pending), 32'h24);
        check("t4_int_out", 32'(a_int_out), 32'h3);
        check("t4_claim_idx", 32'(a_claim_idx), 32'h2);
        a_int_en = 8'hFB;
        #1;
        check("t4_claim_idx_masked", 32'(a_claim_idx), 32'h5);
        tick(1);
        check("t4_int_out_masked", 32'(a_int_out), 32'h2);
        a_int_en = 8'h00;
        #1;
        check("t4_claim_valid_none", 32'(a_claim_valid), 32'h0);
        check("t4_claim_idx_none", 32'(a_claim_idx), 32'h0);
        check("t4_pending_ignores_en", 32'(a_pending), 32'h24);
        tick(1);
        check("t4_int_out_none", 32'(a_int_out), 32'h0);
        a_int_en = 8'hFF; a_int_in = '0;
        tick(4);

        // A clear aimed at a level source is ignored.
        a_int_in[3] = 1'b1;
        tick(3);
        a_clr_valid = 1'b1; a_clr_idx = 3'd3;
        tick(1);
        a_clr_valid = 1'b0;
        check("t5_level_clr_ignored", 32'(a_pending), 32'h08);
        a_int_in[3] = 1'b0;
        tick(4);

        // Instance b has no synchroniser, so pending follows one edge after the input.
        b_int_in[4] = 1'b1;
        tick(1);
        check("t5b_pending", 32'(b_pending), 32'h10);
        b_int_in[4] = 1'b0;
        tick(1);
        check("t5b_int_out", 32'(b_int_out), 32'h2);
        check("t5b_claim_idx", 32'(b_claim_idx), 32'h4);
        b_clr_valid = 1'b1; b_clr_idx = 3'd7;
        tick(1);
        check("t5b_clr_idx7_ignored", 32'(b_pending), 32'h10);
        b_clr_idx = 3'd6;
        tick(1);
        check("t5b_clr_idx6_ignored", 32'(b_pending), 32'h10);
        b_clr_idx = 3'd4;
        tick(1);
        b_clr_valid = 1'b0;
        check("t5b_clr_idx4", 32'(b_pending), 32'h00);
        tick(1);
        check("t5b_int_out_clr", 32'(b_int_out), 32'h0);

        // Edge source held high through a mid-run reset sets exactly once afterwards.
        a_int_in[0] = 1'b1;
        tick(3);
        check("t6_pending_before", 32'(a_pending), 32'h01);
        tick(1);
        reset = 1'b1;
        #1;
        check("t6_async_clear_pending", 32'(a_pending), 32'h00);
        check("t6_async_clear_int_out", 32'(a_int_out), 32'h0);
        tick(2);
        check("t6_pending_in_reset", 32'(a_pending), 32'h00);
        reset = 1'b0;
        tick(2);
        check("t6_pending_e2", 32'(a_pending), 32'h00);
        tick(1);
        check("t6_pending_e3", 32'(a_pending), 32'h01);
        a_clr_valid = 1'b1; a_clr_idx = 3'd0;
        tick(1);
        a_clr_valid = 1'b0;
        check("t6_cleared", 32'(a_pending), 32'h00);
        tick(3);
        check("t6_no_second_set", 32'(a_pending), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
